// File: rtl/serial_bit_source.sv
// Parallel-load, MSB-first serial pattern source with a start/busy/done handshake.
// Feeds the x input of the downstream sequence detector one bit per clock.
module serial_bit_source #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNTW-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            shreg   <= data;
            cnt     <= CNTW'(WIDTH - 1);
            // x is registered, so the first bit is presented straight from data
            x       <= data[WIDTH-1];
            x_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            state   <= DONE;
            x       <= 1'b0;
            x_valid <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
            // Next bit is the one just below the MSB of the pre-shift register
            x   <= shreg[WIDTH-2];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          x       <= 1'b0;
          x_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Directed bench for serial_bit_source: scoreboard for serial bits, per-cycle
// handshake checks, async reset, back-to-back starts and a WIDTH=2 instance.
module tb_serial_bit_source;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       x, x_valid, busy, done;

  logic       start2;
  logic [1:0] data2;
  logic       x2, x_valid2, busy2, done2;

  int checks   = 0;
  int failures = 0;
  logic sbq[$];

  always #5 clk = ~clk;

  serial_bit_source #(.WIDTH(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .x(x), .x_valid(x_valid), .busy(busy), .done(done)
  );

  serial_bit_source #(.WIDTH(2), .CNTW(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .data(data2),
    .x(x2), .x_valid(x_valid2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pattern(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) sbq.push_back(d[i]);
  endtask

  task automatic chk_ctl(input string tag, input int k,
                         input logic ev, input logic eb, input logic ed);
    chk($sformatf("%s_valid_k%0d", tag, k), 32'(x_valid), 32'(ev));
    chk($sformatf("%s_busy_k%0d", tag, k), 32'(busy), 32'(eb));
    chk($sformatf("%s_done_k%0d", tag, k), 32'(done), 32'(ed));
  endtask

  // Serial-bit scoreboard: every valid cycle pops one expected bit
  always @(negedge clk) begin
    if (!rst) begin
      if (x_valid) begin
        if (sbq.size() == 0) chk("sb_unexpected_bit", 32'(1), 32'(0));
        else chk("sb_x_bit", 32'(x), 32'(sbq.pop_front()));
      end else begin
        chk("sb_x_idle_zero", 32'(x), 32'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; data = '0; start2 = 1'b0; data2 = '0;
    repeat (2) @(negedge clk);
    chk_ctl("rst_held", 0, 1'b0, 1'b0, 1'b0);
    chk("rst_held_x", 32'(x), 32'(0));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_ctl("idle_after_rst", 0, 1'b0, 1'b0, 1'b0);

    // Basic pattern with ignored starts and a mid-pattern data change
    data = 8'b0110_1011; start = 1'b1;
    push_pattern(8'b0110_1011);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk_ctl("basic", k, k < 8, k <= 8, k == 8);
      start = (k == 2 || k == 7);
      if (k == 1) data = 8'hFF;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("basic_sb_drained", 32'(sbq.size()), 32'(0));

    // Back-to-back with start held high: one pattern every 10 cycles
    data = 8'hA5; start = 1'b1;
    for (int p = 0; p < 3; p++) push_pattern(8'hA5);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk_ctl("b2b", k, (k % 10) < 8, (k % 10) <= 8, (k % 10) == 8);
      if (k == 29) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_ctl("b2b_end", 0, 1'b0, 1'b0, 1'b0);
    chk("b2b_sb_drained", 32'(sbq.size()), 32'(0));

    // Reset between edges in the middle of an 8'hC3 pattern
    data = 8'hC3; start = 1'b1;
    push_pattern(8'hC3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_ctl("async_rst", 0, 1'b0, 1'b0, 1'b0);
    chk("async_rst_x", 32'(x), 32'(0));
    chk("async_rst_bits_left", 32'(sbq.size()), 32'(4));
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_ctl("post_rst_quiet", k, 1'b0, 1'b0, 1'b0);
    end

    data = 8'h3C; start = 1'b1;
    push_pattern(8'h3C);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk_ctl("after_rst", k, k < 8, k <= 8, k == 8);
    end
    chk("after_rst_sb_drained", 32'(sbq.size()), 32'(0));

    // WIDTH=2 instance: patterns 10, 11 and 00
    for (int t = 0; t < 3; t++) begin
      logic [1:0] d;
      d = (t == 0) ? 2'b10 : (t == 1) ? 2'b11 : 2'b00;
      data2 = d; start2 = 1'b1;
      for (int k = 0; k <= 3; k++) begin
        @(negedge clk);
        start2 = 1'b0;
        chk($sformatf("w2_x_t%0d_k%0d", t, k), 32'(x2),
            32'((k == 0) ? d[1] : (k == 1) ? d[0] : 1'b0));
        chk($sformatf("w2_valid_t%0d_k%0d", t, k), 32'(x_valid2), 32'(k < 2));
        chk($sformatf("w2_busy_t%0d_k%0d", t, k), 32'(busy2), 32'(k <= 2));
        chk($sformatf("w2_done_t%0d_k%0d", t, k), 32'(done2), 32'(k == 2));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream stimulus stage for the 3-bit-state Mealy sequence-detector FSM (ports clk, x, PS, z).
- Loads a parallel pattern word and shifts it out MSB-first, one bit per clk, on the serial line that drives the detector's x input.
- Provides a start/busy/done handshake so a controller can queue patterns back-to-back, replacing hand-timed stimulus.

Parameters:
WIDTH, 8, pattern word width in bits (legal range 2..16)
CNTW, 4, bit-counter width; must satisfy 2^CNTW >= WIDTH

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request to load data and begin shifting; sampled on rising clk
data  input  WIDTH  pattern word; bit WIDTH-1 is sent first
x  output  1  serial bit to detector x input; 0 whenever x_valid=0
x_valid  output  1  high on every cycle that x carries a pattern bit
busy  output  1  high while a pattern is loaded and not yet finished (SHIFT or DONE)
done  output  1  one-cycle pulse after the last bit has been presented

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, shift register=0, bit counter=0, x=0, x_valid=0, busy=0, done=0. All outputs are registered; none depend combinationally on start or data.
- State machine, three states, IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE: start=1 at an edge loads shreg<=data and cnt<=WIDTH-1, and moves to SHIFT. start=0 stays in IDLE.
  - SHIFT: x=shreg[WIDTH-1] and x_valid=1. Each edge shifts shreg left, filling 0, and decrements cnt. The edge with cnt==0 moves to DONE.
  - DONE: x=0, x_valid=0, done=1 for exactly this one cycle. The next edge always returns to IDLE.
- Latency and throughput:
  - Start accepted at edge N: bit WIDTH-1 is on x from edge N through N+1.
  - Bit 0 is on x from edge N+WIDTH-1 through N+WIDTH.
  - done is high from edge N+WIDTH through N+WIDTH+1. busy falls at edge N+WIDTH+1.
  - Exactly WIDTH consecutive x_valid cycles per pattern, with no gaps.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Handshake rules:
  - start is ignored while busy=1 (SHIFT or DONE). It is not queued.
  - data is sampled only on the accepting edge; changes to data mid-pattern have no effect.
  - start held high continuously yields patterns separated by one DONE cycle and one IDLE cycle.
- Boundary conditions:
  - WIDTH=2: SHIFT lasts exactly 2 cycles.
  - data all-zeros or all-ones: still WIDTH valid cycles and a done pulse.
  - start on the same edge as the DONE->IDLE transition: ignored, because the FSM is still in DONE at that edge.
  - rst asserted mid-SHIFT: outputs go to reset values immediately, not waiting for an edge; the pattern is abandoned and no done pulse is issued.
  - After rst deasserts, the first start is accepted normally.
- Downstream timing: the detector samples x on the same clk. x changes only on rising edges, so it is stable for a full period around each detector sampling edge.

Test Plan:
- Reset: assert rst asynchronously between edges -> x=0, x_valid=0, busy=0, done=0 before the next edge. After release, outputs hold until start.
- Basic pattern: WIDTH=8, data=8'b0110_1011, start for one cycle at edge N -> x sequence 0,1,1,0,1,0,1,1 on cycles N..N+7, x_valid=1 on those 8 cycles, done=1 only in cycle N+8, busy high for 9 cycles.
- Ignored start and data change: start pulsed at edges N+3 and N+8 of the above run, data changed to 8'hFF at N+2 -> sent bits unchanged, no second pattern, busy falls at N+9.
- Back-to-back: start held high, data=8'hA5 -> patterns begin every 10 cycles. Each emits 1,0,1,0,0,1,0,1 followed by one done cycle and one idle cycle.
- Reset mid-operation: rst pulsed at cycle N+4 of an 8'hC3 pattern -> x and x_valid drop to 0 immediately, no done pulse. A new start with 8'h3C emits 0,0,1,1,1,1,0,0.
- Detector integration: feed the detector's x from this block with a pattern equal to its reference stimulus bit order -> the detector's PS and z traces match that stimulus cycle for cycle.
